// File: rtl/modadd_scheduler.sv
// Round-robin arbiter/sequencer sharing one modadder among NUM_REQ requesters.
// Optional build macro: MODADD_SCHED_STATS_EN adds a saturating op_count output.
module modadd_scheduler #(
  parameter int WIDTH   = 381,
  parameter int NUM_REQ = 3,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_subtract,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [WIDTH-1:0]         in_m,
  output logic [NUM_REQ-1:0]       rsp_ack,
  output logic [WIDTH-1:0]         rsp_result,
  output logic [IDW-1:0]           grant_id,
  output logic                     busy,
  output logic [WIDTH-1:0]         ma_in_a,
  output logic [WIDTH-1:0]         ma_in_b,
  output logic [WIDTH-1:0]         ma_in_m,
  output logic                     ma_subtract,
  output logic                     ma_start,
  input  logic [WIDTH-1:0]         ma_result,
  input  logic                     ma_done,
`ifdef MODADD_SCHED_STATS_EN
  output logic [15:0]              op_count,
`endif
  output logic [1:0]               state_dbg
);

  // Handshake: a requester holds req_valid[i] until the cycle rsp_ack[i] is
  // high; on that edge it either drops req_valid[i] or presents its next op.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]       state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant_sel;
  logic [IDW-1:0]   idx;
  logic [IDW-1:0]   next_ptr;
  logic [WIDTH-1:0] a_arr [NUM_REQ];
  logic [WIDTH-1:0] b_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
    assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
  end

  // Scan downward so the last hit is the first set bit at or above rr_ptr.
  always_comb begin
    grant_sel = rr_ptr;
    idx       = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (int'(rr_ptr) + k >= NUM_REQ)
        idx = IDW'(int'(rr_ptr) + k - NUM_REQ);
      else
        idx = IDW'(int'(rr_ptr) + k);
      if (req_valid[idx]) grant_sel = idx;
    end
  end

  assign next_ptr  = (grant_sel == IDW'(NUM_REQ-1)) ? '0 : grant_sel + 1'b1;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      rsp_ack     <= '0;
      rsp_result  <= '0;
      ma_in_a     <= '0;
      ma_in_b     <= '0;
      ma_in_m     <= '0;
      ma_subtract <= 1'b0;
      ma_start    <= 1'b0;
    end else begin
      rsp_ack  <= '0;
      ma_start <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            ma_in_a     <= a_arr[grant_sel];
            ma_in_b     <= b_arr[grant_sel];
            ma_in_m     <= in_m;
            ma_subtract <= req_subtract[grant_sel];
            grant_id    <= grant_sel;
            rr_ptr      <= next_ptr;
            ma_start    <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (ma_done) begin
            rsp_result <= ma_result;
            rsp_ack    <= NUM_REQ'(1) << grant_id;
            state      <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MODADD_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (!resetn)
      op_count <= '0;
    else if (|rsp_ack && op_count != 16'hFFFF)
      op_count <= op_count + 16'd1;
  end
`endif

endmodule
